// File: rtl/parity_frame_tx.sv
`default_nettype none
// ============================================================================
// Module   : parity_frame_tx
// Function : Serial frame transmitter: start, DATA_W data bits LSB first,
//            parity, stop. Optional macro PARITY_FRAME_EVEN_SEL_EN adds
//            even_sel to choose even parity per frame (odd by default).
// Revision : 1.0 - initial release
// ============================================================================
module parity_frame_tx #(
  parameter int DATA_W   = 4,
  parameter int BAUD_DIV = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
`ifdef PARITY_FRAME_EVEN_SEL_EN
  input  logic              even_sel,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [7:0] BAUD_LAST = 8'(BAUD_DIV - 1);
  localparam logic [4:0] BIT_LAST  = 5'(DATA_W - 1);

  state_t            state;
  logic [4:0]        bit_cnt;
  logic [7:0]        baud_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par;

  logic              baud_end;
  logic [DATA_W-1:0] shreg_next;
  logic              par_new;

  assign in_ready   = (state == IDLE);
  assign baud_end   = (baud_cnt == BAUD_LAST);
  assign shreg_next = shreg >> 1;

`ifdef PARITY_FRAME_EVEN_SEL_EN
  assign par_new = even_sel ? (^data_in) : (~^data_in);
`else
  assign par_new = ~^data_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx_out     <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      baud_cnt   <= '0;
      shreg      <= '0;
      par        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx_out <= 1'b1;
          if (in_valid) begin
            shreg    <= data_in;
            par      <= par_new;
            state    <= START;
            tx_out   <= 1'b0;
            busy     <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= DATA;
            tx_out   <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            shreg    <= shreg_next;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= PARITY;
              tx_out  <= par;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
              tx_out  <= shreg_next[0];
            end
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        PARITY: begin
          if (baud_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx_out   <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        STOP: begin
          // frame_done marks the first IDLE cycle, when a new word may already be taken
          if (baud_end) begin
            baud_cnt   <= '0;
            state      <= IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 8'd1;
          end
        end
        default: begin
          state  <= IDLE;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_parity_frame_tx.sv
`default_nettype none
// Bench for parity_frame_tx: two instances (BAUD_DIV=1 and 3) driven by
// directed and random frames, compared against a bit-list frame model.
module tb_parity_frame_tx;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] d1 = '0, d3 = '0;
  logic         v1 = 1'b0, v3 = 1'b0;
  logic         tx1, rdy1, busy1, fd1;
  logic         tx3, rdy3, busy3, fd3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  parity_frame_tx #(.DATA_W(W), .BAUD_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .data_in(d1), .in_valid(v1),
    .in_ready(rdy1), .tx_out(tx1), .busy(busy1), .frame_done(fd1)
  );

  parity_frame_tx #(.DATA_W(W), .BAUD_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .data_in(d3), .in_valid(v3),
    .in_ready(rdy3), .tx_out(tx3), .busy(busy3), .frame_done(fd3)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic drive(input int sel, input logic [W-1:0] d, input logic v);
    if (sel == 3) begin d3 = d; v3 = v; end
    else          begin d1 = d; v1 = v; end
  endtask

  // {tx_out, busy, in_ready, frame_done}
  function automatic logic [3:0] outs(input int sel);
    return (sel == 3) ? {tx3, busy3, rdy3, fd3} : {tx1, busy1, rdy1, fd1};
  endfunction

  // Called at a negedge with the DUT idle; returns at the frame_done negedge.
  task automatic run_frame(input int sel, input logic [W-1:0] d, input bit noise);
    int           b;
    logic         bits[$];
    logic [3:0]   o;
    logic [W-1:0] rnd;
    b = (sel == 3) ? 3 : 1;
    bits.push_back(1'b0);
    for (int i = 0; i < W; i++) bits.push_back(d[i]);
    bits.push_back(($countones(d) % 2) == 0);
    bits.push_back(1'b1);
    o = outs(sel);
    chk($sformatf("d%0d ready_at_accept", sel), o[1], 1'b1);
    drive(sel, d, 1'b1);
    for (int c = 0; c < bits.size() * b; c++) begin
      @(negedge clk);
      o = outs(sel);
      chk($sformatf("d%0d data=%h tx cyc%0d", sel, d, c), o[3], bits[c / b]);
      chk($sformatf("d%0d busy cyc%0d", sel, c), o[2], 1'b1);
      chk($sformatf("d%0d ready cyc%0d", sel, c), o[1], 1'b0);
      chk($sformatf("d%0d done cyc%0d", sel, c), o[0], 1'b0);
      rnd = W'($urandom);
      drive(sel, rnd, noise);
    end
    @(negedge clk);
    o = outs(sel);
    chk($sformatf("d%0d end tx", sel), o[3], 1'b1);
    chk($sformatf("d%0d end busy", sel), o[2], 1'b0);
    chk($sformatf("d%0d end ready", sel), o[1], 1'b1);
    chk($sformatf("d%0d end frame_done", sel), o[0], 1'b1);
    drive(sel, '0, 1'b0);
  endtask

  initial begin
    logic [3:0]   o;
    logic [W-1:0] rd;
    int           sel;

    repeat (2) @(negedge clk);
    for (int s = 1; s <= 3; s += 2) begin
      o = outs(s);
      chk($sformatf("d%0d reset tx", s), o[3], 1'b1);
      chk($sformatf("d%0d reset busy", s), o[2], 1'b0);
      chk($sformatf("d%0d reset ready", s), o[1], 1'b1);
      chk($sformatf("d%0d reset done", s), o[0], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    run_frame(1, 4'b0000, 1'b0);
    @(negedge clk);
    run_frame(1, 4'b1011, 1'b0);
    @(negedge clk);
    run_frame(3, 4'b0001, 1'b0);
    @(negedge clk);

    // back-to-back with noisy in_valid/data_in while busy
    run_frame(1, 4'b0110, 1'b1);
    run_frame(1, 4'b1100, 1'b1);
    run_frame(3, 4'b1110, 1'b1);
    run_frame(3, 4'b0111, 1'b1);
    @(negedge clk);

    // reset during DATA bit 2
    drive(1, 4'b1010, 1'b1);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      drive(1, 4'b1111, 1'b1);
    end
    o = outs(1);
    chk("mid tx bit2", o[3], 1'b0);
    rst = 1'b1;
    @(negedge clk);
    o = outs(1);
    chk("mid rst tx", o[3], 1'b1);
    chk("mid rst busy", o[2], 1'b0);
    chk("mid rst done", o[0], 1'b0);
    chk("mid rst ready", o[1], 1'b1);
    rst = 1'b0;
    drive(1, '0, 1'b0);
    @(negedge clk);
    o = outs(1);
    chk("post rst done", o[0], 1'b0);
    chk("post rst busy", o[2], 1'b0);
    run_frame(1, 4'b0101, 1'b0);

    for (int k = 0; k < 24; k++) begin
      sel = ($urandom_range(0, 1) == 0) ? 1 : 3;
      rd  = W'($urandom);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      run_frame(sel, rd, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
